// File: rtl/delay_path_sequencer.sv
// rtl/delay_path_sequencer.sv - launch/time/accumulate controller for one delay path
// Optional DELAY_SEQ_MINMAX_EN adds per-run delay_min/delay_max outputs.
module delay_path_sequencer #(
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int TIMEOUT    = 1023,
    parameter bit INVERT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       trials,
    input  logic [CNT_W-1:0] golden,
    input  logic [CNT_W-1:0] tolerance,
    output logic             path_input,
    input  logic             path_result,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] delay_sum,
    output logic             timeout_err,
`ifdef DELAY_SEQ_MINMAX_EN
    output logic             suspect,
    output logic [CNT_W-1:0] delay_min,
    output logic [CNT_W-1:0] delay_max
`else
    output logic             suspect
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        WAIT,
        RECORD,
        DONE
    } stateT;

    localparam logic [CNT_W-1:0] TIMEOUT_V     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LAST_V = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    stateT            state;
    logic             resMeta;
    logic             resSync;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       trialsLat;
    logic [7:0]       trialsDone;
    logic [CNT_W-1:0] goldenLat;
    logic [CNT_W-1:0] tolLat;

    logic             settled;
    logic [7:0]       trialsNext;
    logic [CNT_W:0]   sumWide;
    logic [CNT_W-1:0] sumNext;
    logic [CNT_W-1:0] absDiff;

    // The path has settled once the synchronized output matches what the current input implies.
    assign settled    = (resSync == (path_input ^ INVERT));
    assign trialsNext = trialsDone + 8'd1;
    assign sumWide    = {1'b0, delay_sum} + {1'b0, cnt};
    assign sumNext    = sumWide[CNT_W] ? {CNT_W{1'b1}} : sumWide[CNT_W-1:0];
    assign absDiff    = (delay_sum >= goldenLat) ? (delay_sum - goldenLat) : (goldenLat - delay_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            resMeta     <= 1'b0;
            resSync     <= 1'b0;
            cnt         <= '0;
            trialsLat   <= '0;
            trialsDone  <= '0;
            goldenLat   <= '0;
            tolLat      <= '0;
            path_input  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            delay_sum   <= '0;
            timeout_err <= 1'b0;
            suspect     <= 1'b0;
`ifdef DELAY_SEQ_MINMAX_EN
            delay_min   <= {CNT_W{1'b1}};
            delay_max   <= '0;
`endif
        end else begin
            resMeta <= path_result;
            resSync <= resMeta;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    // The cycle carrying done still ignores start.
                    if (start && (trials != 8'd0) && !done) begin
                        trialsLat   <= trials;
                        goldenLat   <= golden;
                        tolLat      <= tolerance;
                        trialsDone  <= '0;
                        cnt         <= '0;
                        path_input  <= 1'b0;
                        delay_sum   <= '0;
                        timeout_err <= 1'b0;
                        suspect     <= 1'b0;
                        busy        <= 1'b1;
`ifdef DELAY_SEQ_MINMAX_EN
                        delay_min   <= {CNT_W{1'b1}};
                        delay_max   <= '0;
`endif
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if ((cnt >= SETTLE_LAST_V) && settled) begin
                        state <= LAUNCH;
                    end else if (cnt >= TIMEOUT_V) begin
                        timeout_err <= 1'b1;
                        suspect     <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    path_input <= ~path_input;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (settled) begin
                        state <= RECORD;
                    end else if (cnt >= TIMEOUT_V) begin
                        timeout_err <= 1'b1;
                        suspect     <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECORD: begin
                    delay_sum  <= sumNext;
                    trialsDone <= trialsNext;
`ifdef DELAY_SEQ_MINMAX_EN
                    if (cnt < delay_min) delay_min <= cnt;
                    if (cnt > delay_max) delay_max <= cnt;
`endif
                    cnt <= '0;
                    if (trialsNext == trialsLat) begin
                        state <= DONE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    if (absDiff > tolLat) suspect <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_path_sequencer.sv
// tb/tb_delay_path_sequencer.sv - randomized self-checking bench for delay_path_sequencer
`timescale 1ns/1ps
module tb_delay_path_sequencer;

    localparam int SETTLE_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  trials;
    logic [15:0] golden;
    logic [15:0] tolerance;
    logic        path_input;
    logic        path_result = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] delay_sum;
    logic        timeout_err;
    logic        suspect;
`ifdef DELAY_SEQ_MINMAX_EN
    logic [15:0] delay_min;
    logic [15:0] delay_max;
`endif

    always #5 clk = ~clk;

    delay_path_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .trials      (trials),
        .golden      (golden),
        .tolerance   (tolerance),
        .path_input  (path_input),
        .path_result (path_result),
        .busy        (busy),
        .done        (done),
        .delay_sum   (delay_sum),
        .timeout_err (timeout_err),
`ifdef DELAY_SEQ_MINMAX_EN
        .suspect     (suspect),
        .delay_min   (delay_min),
        .delay_max   (delay_max)
`else
        .suspect     (suspect)
`endif
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Delay path: output follows input D clock edges after the input changes (separate D per direction).
    int   dRise  = 3;
    int   dFall  = 3;
    bit   stuck  = 1'b0;
    logic tgt    = 1'b0;
    int   remain = 0;

    always @(posedge clk) begin
        if (stuck) begin
            path_result <= 1'b0;
            tgt         <= path_input;
            remain      <= 0;
        end else if (path_input != tgt) begin
            tgt <= path_input;
            if ((path_input ? dRise : dFall) <= 1) begin
                path_result <= path_input;
                remain      <= 0;
            end else begin
                remain <= (path_input ? dRise : dFall) - 1;
            end
        end else if (remain > 1) begin
            remain <= remain - 1;
        end else if (remain == 1) begin
            remain      <= 0;
            path_result <= tgt;
        end else if (path_result != tgt) begin
            if ((tgt ? dRise : dFall) <= 1) path_result <= tgt;
            else remain <= (tgt ? dRise : dFall) - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, owned by the driver.
    bit runOn = 1'b0;
    bit runLoose = 1'b0;
    int runDur = 0;
    int s0Edge = 0;
    int expSum = 0, expMin = 65535, expMax = 0;
    bit expTo = 1'b0, expSus = 1'b0, expPath = 1'b0;
    int hSum = 0, hMin = 65535, hMax = 0;
    bit hTo = 1'b0, hSus = 1'b0, hPath = 1'b0;

    int finishCount = 0;
    int doneTotal   = 0;

    task automatic checkResults();
        check("sum", delay_sum, expSum);
        check("timeout_err", timeout_err, expTo);
        check("suspect", suspect, expSus);
        check("path_input_end", path_input, expPath);
`ifdef DELAY_SEQ_MINMAX_EN
        check("delay_min", delay_min, expMin);
        check("delay_max", delay_max, expMax);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) doneTotal <= doneTotal + 1;
            if (runOn) begin
                if (cyc - s0Edge == 0) begin
                    check("start_clears_sum", delay_sum, 0);
                    check("start_clears_to", timeout_err, 0);
                    check("start_clears_sus", suspect, 0);
`ifdef DELAY_SEQ_MINMAX_EN
                    check("start_init_min", delay_min, 65535);
                    check("start_init_max", delay_max, 0);
`endif
                end
                if (runLoose) begin
                    check("busy_until_done", busy, !done);
                    if (done) begin
                        checkResults();
                        finishCount <= finishCount + 1;
                    end
                end else begin
                    check("busy_window", busy, (cyc - s0Edge) < runDur);
                    check("done_window", done, (cyc - s0Edge) == runDur);
                    if (cyc - s0Edge == runDur) begin
                        checkResults();
                        finishCount <= finishCount + 1;
                    end
                end
            end else begin
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("hold_sum", delay_sum, hSum);
                check("hold_to", timeout_err, hTo);
                check("hold_sus", suspect, hSus);
                check("hold_path", path_input, hPath);
`ifdef DELAY_SEQ_MINMAX_EN
                check("hold_min", delay_min, hMin);
                check("hold_max", delay_max, hMax);
`endif
            end
        end
    end

    function automatic int modelSum(input int nT, input int dR, input int dF);
        int s = 0;
        for (int i = 0; i < nT; i++) begin
            s += ((i % 2 == 0) ? dR : dF) + 2;
            if (s > 65535) s = 65535;
        end
        return s;
    endfunction

    task automatic startRun(input int nT, input int dR, input int dF, input int g, input int tl,
                            input bit stk);
        int d, diff;
        expSum = modelSum(nT, dR, dF);
        expMin = 65535;
        expMax = 0;
        runDur = 1;
        for (int i = 0; i < nT; i++) begin
            d = (i % 2 == 0) ? dR : dF;
            if (d + 2 < expMin) expMin = d + 2;
            if (d + 2 > expMax) expMax = d + 2;
            runDur += SETTLE_CYC + d + 5;
        end
        // A path left high must first fall back (dF + 2 cycles incl. sync) before the first launch.
        if (hPath && (dF + 3 > SETTLE_CYC)) runDur += dF + 3 - SETTLE_CYC;
        if (stk) begin
            expSum = 0;
            expMin = 65535;
            expMax = 0;
        end
        diff     = (expSum > g) ? expSum - g : g - expSum;
        expTo    = stk;
        expSus   = stk || (diff > tl);
        expPath  = stk ? 1'b1 : 1'(nT % 2);
        runLoose = stk;
        @(posedge clk); #1;
        dRise = dR; dFall = dF; stuck = stk;
        start = 1'b1; trials = 8'(nT); golden = 16'(g); tolerance = 16'(tl);
        @(posedge clk); #1;
        start = 1'b0; trials = 8'($urandom); golden = 16'($urandom); tolerance = 16'($urandom);
        s0Edge = cyc;
        runOn  = 1'b1;
    endtask

    task automatic finishRun(input string tag, input int pokeAt, input bit pokeDone);
        int seen, waited, lim;
        seen   = finishCount;
        waited = 0;
        lim    = runLoose ? 4000 : runDur + 40;
        while (finishCount == seen && waited < lim) begin
            @(negedge clk); #1;
            waited++;
            if (pokeAt > 0) start = (waited == pokeAt);
        end
        start = 1'b0;
        if (finishCount == seen) check({tag, "_run_timeout"}, 0, 1);
        runOn = 1'b0;
        hSum = expSum; hTo = expTo; hSus = expSus; hPath = expPath; hMin = expMin; hMax = expMax;
        if (pokeDone) begin
            start = 1'b1; trials = 8'd3;
            @(posedge clk); #1;
            start = 1'b0;
        end
        stuck = 1'b0;
        repeat (30) @(posedge clk);
    endtask

    task automatic doRun(input string tag, input int nT, input int dR, input int dF, input int g,
                         input int tl, input bit stk, input int pokeAt, input bit pokeDone);
        startRun(nT, dR, dF, g, tl, stk);
        finishRun(tag, pokeAt, pokeDone);
    endtask

    initial begin
        int nT, dR, dF, s, off, tl, g, d0;
        rst_n = 1'b0; start = 1'b0; trials = 8'd0; golden = 16'd0; tolerance = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_path_input", path_input, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", delay_sum, 0);
        check("reset_sus", suspect, 0);
        repeat (5) @(posedge clk);

        d0 = doneTotal;
        doRun("t1", 4, 3, 3, 20, 0, 1'b0, 0, 1'b0);
        check("t1_model_sum", expSum, 20);
        check("t1_sum", delay_sum, 20);
        check("t1_sus", suspect, 0);
        check("t1_done_once", doneTotal - d0, 1);

        doRun("t2", 4, 4, 4, 20, 2, 1'b0, 5, 1'b1);
        check("t2_sum", delay_sum, 24);
        check("t2_sus", suspect, 1);

        d0 = doneTotal;
        doRun("t3", 2, 3, 3, 0, 0, 1'b1, 0, 1'b0);
        check("t3_to", timeout_err, 1);
        check("t3_sus", suspect, 1);
        check("t3_done_once", doneTotal - d0, 1);

        d0 = doneTotal;
        @(posedge clk); #1;
        start = 1'b1; trials = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("t4_zero_busy", busy, 0);
        check("t4_zero_no_done", doneTotal - d0, 0);
        doRun("t4", 1, 1, 1, 3, 0, 1'b0, 0, 1'b0);
        check("t4_sum", delay_sum, 3);

        startRun(3, 10, 10, 36, 0, 1'b0);
        repeat (64) @(posedge clk);
        #1;
        check("t5_pre_path", path_input, 1);
        check("t5_pre_sum", delay_sum, 24);
        rst_n = 1'b0;
        runOn = 1'b0;
        hSum = 0; hTo = 1'b0; hSus = 1'b0; hPath = 1'b0; hMin = 65535; hMax = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t5_rst_path", path_input, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_sum", delay_sum, 0);
        repeat (30) @(posedge clk);
        doRun("t5", 2, 2, 2, 8, 0, 1'b0, 0, 1'b0);
        check("t5_sum", delay_sum, 8);

        doRun("t6", 4, 3, 5, 24, 0, 1'b0, 0, 1'b0);
        check("t6_sum", delay_sum, 24);
`ifdef DELAY_SEQ_MINMAX_EN
        check("t6_min", delay_min, 5);
        check("t6_max", delay_max, 7);
`endif

        doRun("maxtrials", 255, 1, 1, 765, 0, 1'b0, 0, 1'b0);
        check("maxtrials_sum", delay_sum, 765);

        for (int r = 0; r < 18; r++) begin
            nT  = $urandom_range(1, 6);
            dR  = $urandom_range(1, 12);
            dF  = $urandom_range(1, 12);
            s   = modelSum(nT, dR, dF);
            off = int'($urandom_range(0, 12)) - 6;
            tl  = (r % 4 == 0) ? ((off < 0) ? -off : off) : int'($urandom_range(0, 6));
            g   = s + off;
            doRun("rand", nT, dR, dF, g, tl, 1'b0, (r % 2 == 1) ? int'($urandom_range(1, 12)) : 0,
                  (r % 3 == 0));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
